// File: rtl/dvfs_transition_sequencer.sv
// Applies a requested voltage/frequency code pair to the regulator and PLL in a safe order.
// Voltage is raised before frequency and lowered after it, with an ack/lock timeout that sets a sticky fault.
module dvfs_transition_sequencer #(
  parameter logic [1:0]  RESET_V        = 2'b01,
  parameter logic [2:0]  RESET_F        = 3'b010,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned LOCK_BLANK     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] tgt_v,
  input  logic [2:0] tgt_f,
  input  logic       vreg_ack,
  input  logic       pll_lock,
  input  logic       fault_clr,
  output logic [1:0] v_out,
  output logic [2:0] f_out,
  output logic       vreg_req,
  output logic       pll_relock,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    IDLE, V_RAISE, V_SETTLE_UP, F_SET, F_LOCK, V_LOWER, V_SETTLE_DN, FAULT
  } state_t;

  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] BLANK        = 8'(LOCK_BLANK);

  state_t     state, state_d;
  logic [1:0] tv, tv_d, v_d;
  logic [2:0] tf, tf_d, f_d;
  logic [7:0] cnt, cnt_d;
  logic       req_d, relock_d, done_d, fault_d;
  logic       freq_phase_done;

  // NOTE: every state element is updated with <= so all registers see the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tv         <= RESET_V;
      tf         <= RESET_F;
      v_out      <= RESET_V;
      f_out      <= RESET_F;
      cnt        <= '0;
      vreg_req   <= 1'b0;
      pll_relock <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_d;
      tv         <= tv_d;
      tf         <= tf_d;
      v_out      <= v_d;
      f_out      <= f_d;
      cnt        <= cnt_d;
      vreg_req   <= req_d;
      pll_relock <= relock_d;
      done       <= done_d;
      fault      <= fault_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d         = state;
    tv_d            = tv;
    tf_d            = tf;
    v_d             = v_out;
    f_d             = f_out;
    cnt_d           = cnt;
    req_d           = vreg_req;
    relock_d        = 1'b0;
    done_d          = 1'b0;
    fault_d         = fault;
    freq_phase_done = 1'b0;

    case (state)
      IDLE: begin
        if ({tgt_v, tgt_f} != {v_out, f_out}) begin
          tv_d  = tgt_v;
          tf_d  = tgt_f;
          cnt_d = '0;
          if (tgt_v > v_out) begin
            state_d = V_RAISE;
            v_d     = tgt_v;
            req_d   = 1'b1;
          end else begin
            state_d = F_SET;
          end
        end
      end
      V_RAISE, V_LOWER: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (vreg_ack) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = (state == V_RAISE) ? V_SETTLE_UP : V_SETTLE_DN;
        end else if (cnt == TIMEOUT_LAST) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = FAULT;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      V_SETTLE_UP, V_SETTLE_DN: begin
        if (cnt == SETTLE_LAST) begin
          cnt_d = '0;
          if (state == V_SETTLE_UP) begin
            state_d = F_SET;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      F_SET: begin
        if (tf == f_out) begin
          freq_phase_done = 1'b1;
        end else begin
          f_d      = tf;
          relock_d = 1'b1;
          cnt_d    = '0;
          state_d  = F_LOCK;
        end
      end
      F_LOCK: begin
        // The blank window and the timeout both count from F_LOCK entry.
        if (cnt >= BLANK && pll_lock) begin
          freq_phase_done = 1'b1;
        end else if (cnt == TIMEOUT_LAST) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      FAULT: begin
        if (fault_clr) begin
          fault_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (freq_phase_done) begin
      if (tv < v_out) begin
        state_d = V_LOWER;
        v_d     = tv;
        req_d   = 1'b1;
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  assign busy = (state != IDLE) && (state != FAULT);

endmodule

// File: tb/tb_dvfs_transition_sequencer.sv
// Self-checking bench: regulator/PLL responder plus a phase-timeline model of each transition.
// Directed scenarios first, then randomized transitions, then reset during frequency lock.
module tb_dvfs_transition_sequencer;

  localparam int S = 8;    // settle cycles
  localparam int B = 2;    // lock blank cycles
  localparam int T = 255;  // ack/lock timeout

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] tgt_v;
  logic [2:0] tgt_f;
  logic       vreg_ack, pll_lock, fault_clr;
  logic [1:0] v_out;
  logic [2:0] f_out;
  logic       vreg_req, pll_relock, busy, done, fault;

  int checks = 0;
  int errors = 0;
  int a_delay, l_delay, req_age, lock_age;
  logic [1:0] mv;
  logic [2:0] mf;
  bit clr_noise = 1'b0;

  always #5 clk = ~clk;

  dvfs_transition_sequencer dut (
    .clk(clk), .reset(reset), .tgt_v(tgt_v), .tgt_f(tgt_f),
    .vreg_ack(vreg_ack), .pll_lock(pll_lock), .fault_clr(fault_clr),
    .v_out(v_out), .f_out(f_out), .vreg_req(vreg_req), .pll_relock(pll_relock),
    .busy(busy), .done(done), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then play the regulator and PLL.
  task automatic step();
    @(negedge clk);
    if (vreg_req) begin
      if (req_age == a_delay) vreg_ack = 1'b1;
      req_age++;
    end else begin
      req_age  = 0;
      vreg_ack = 1'b0;
    end
    if (pll_relock) begin
      lock_age = 0;
      pll_lock = (l_delay == 0);
    end else begin
      lock_age++;
      if (lock_age >= l_delay) pll_lock = 1'b1;
    end
    if (clr_noise) fault_clr = 1'($urandom_range(0, 1));
  endtask

  task automatic check_all(input string tag, input int k, input logic [1:0] ev, input logic [2:0] ef,
                           input bit ereq, input bit erel, input bit ebusy, input bit edone,
                           input bit efault);
    check($sformatf("%s.v_out@%0d", tag, k), v_out, ev);
    check($sformatf("%s.f_out@%0d", tag, k), f_out, ef);
    check($sformatf("%s.vreg_req@%0d", tag, k), vreg_req, ereq);
    check($sformatf("%s.pll_relock@%0d", tag, k), pll_relock, erel);
    check($sformatf("%s.busy@%0d", tag, k), busy, ebusy);
    check($sformatf("%s.done@%0d", tag, k), done, edone);
    check($sformatf("%s.fault@%0d", tag, k), fault, efault);
  endtask

  // Called at a falling edge while the DUT is in IDLE (cycle 0). Builds the expected
  // timeline of the transition from the ordering rules, then checks it cycle by cycle.
  task automatic run(input string tag, input logic [1:0] tv, input logic [2:0] tf,
                     input int a, input int l, input bit drive,
                     input bit chain, input logic [1:0] nv, input logic [2:0] nf);
    logic [1:0] cv;
    logic [2:0] cf;
    int vr_s, vr_e, v_chg, r, c, fin, j, last;
    bit flt, raise, lower, fchg;
    cv = mv; cf = mf;
    a_delay = a; l_delay = l;
    if (drive) begin tgt_v = tv; tgt_f = tf; end
    raise = (tv > cv); lower = (tv < cv); fchg = (tf != cf);
    vr_s = -1; vr_e = -1; v_chg = -1; r = -1; flt = 1'b0; fin = 0; c = 1;
    if (raise) begin
      v_chg = 1; vr_s = 1;
      if (a <= T - 1) begin vr_e = 1 + a; c = 2 + a + S; end
      else begin vr_e = T; fin = 1 + T; flt = 1'b1; end
    end
    if (!flt) begin
      if (fchg) begin
        r = c + 1;
        j = (l > B) ? l : B;
        if (j <= T - 1) c = r + j + 1;
        else begin fin = r + T; flt = 1'b1; end
      end else begin
        c = c + 1;
      end
    end
    if (!flt) begin
      if (lower) begin
        v_chg = c; vr_s = c;
        if (a <= T - 1) begin vr_e = c + a; fin = c + a + S + 1; end
        else begin vr_e = c + T - 1; fin = c + T; flt = 1'b1; end
      end else begin
        fin = c;
      end
    end
    last = chain ? fin : fin + 2;
    for (int k = 1; k <= last; k++) begin
      step();
      if (chain && k == 2) begin tgt_v = nv; tgt_f = nf; end
      check_all(tag, k,
                (v_chg >= 0 && k >= v_chg) ? tv : cv,
                (r >= 0 && k >= r) ? tf : cf,
                (vr_s >= 0 && k >= vr_s && k <= vr_e),
                (k == r), (k < fin), (!flt && k == fin), (flt && k >= fin));
    end
    mv = (v_chg >= 0) ? tv : cv;
    mf = (r >= 0) ? tf : cf;
  endtask

  task automatic hold_fault(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      check_all(tag, k, mv, mf, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic clear_fault(input string tag);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check($sformatf("%s.fault", tag), fault, 1'b0);
    check($sformatf("%s.busy", tag), busy, 1'b0);
  endtask

  initial begin
    logic [1:0] rv;
    logic [2:0] rf;
    int guard;
    reset = 1'b0; tgt_v = 2'b01; tgt_f = 3'b010;
    vreg_ack = 1'b0; pll_lock = 1'b0; fault_clr = 1'b0;
    a_delay = 0; l_delay = 0; req_age = 0; lock_age = 0;
    mv = 2'b01; mf = 3'b010;
    #17;
    check("rst.v_out", v_out, 2'b01);
    check("rst.f_out", f_out, 3'b010);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      check_all("idle", k, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    run("raise", 2'd3, 3'd7, 3, 4, 1'b1, 1'b0, 2'd0, 3'd0);
    run("lower", 2'd0, 3'd0, 3, 4, 1'b1, 1'b0, 2'd0, 3'd0);
    run("back", 2'd1, 3'd2, 2, 1, 1'b1, 1'b0, 2'd0, 3'd0);
    run("fonly", 2'd1, 3'd1, 0, 0, 1'b1, 1'b0, 2'd0, 3'd0);

    run("ack_to", 2'd3, 3'd7, 1000, 0, 1'b1, 1'b0, 2'd0, 3'd0);
    tgt_v = 2'd0; tgt_f = 3'd0;
    hold_fault("frozen", 10);
    clear_fault("clr1");
    run("after_clr", 2'd0, 3'd0, 2, 3, 1'b0, 1'b0, 2'd0, 3'd0);

    run("ack_edge", 2'd2, 3'd5, T - 1, 1, 1'b1, 1'b0, 2'd0, 3'd0);
    run("lock_edge", 2'd3, 3'd0, 2, T - 1, 1'b1, 1'b0, 2'd0, 3'd0);
    run("lock_to", 2'd1, 3'd3, 2, 1000, 1'b1, 1'b0, 2'd0, 3'd0);
    hold_fault("frozen2", 3);
    clear_fault("clr2");
    run("after_clr2", 2'd1, 3'd3, 2, 2, 1'b0, 1'b0, 2'd0, 3'd0);

    run("chain1", 2'd3, 3'd7, 2, 3, 1'b1, 1'b1, 2'd0, 3'd0);
    run("chain2", 2'd0, 3'd0, 4, 1, 1'b0, 1'b0, 2'd0, 3'd0);

    clr_noise = 1'b1;
    for (int n = 0; n < 30; n++) begin
      do begin
        rv = 2'($urandom_range(0, 3));
        rf = 3'($urandom_range(0, 7));
      end while ({rv, rf} == {mv, mf});
      run("rand", rv, rf, int'($urandom_range(0, 10)), int'($urandom_range(0, 6)),
          1'b1, 1'b0, 2'd0, 3'd0);
    end
    clr_noise = 1'b0;
    fault_clr = 1'b0;

    // Reset in the middle of F_LOCK returns the codes to their reset values at once.
    l_delay = 1000; a_delay = 1;
    tgt_v = (mv == 2'd3) ? 2'd0 : 2'd3;
    tgt_f = mf + 3'd1;
    guard = 0;
    while (pll_relock !== 1'b1 && guard < 600) begin
      step();
      guard++;
    end
    check("relock_seen", {31'd0, guard < 600}, 32'd1);
    step();
    check("in_lock.busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_all("midrst", 0, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tgt_v = 2'b01; tgt_f = 3'b010;
    vreg_ack = 1'b0; pll_lock = 1'b0; req_age = 0; lock_age = 0;
    mv = 2'b01; mf = 3'b010;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_all("postrst", k, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvfs_transition_sequencer.md
Name: dvfs_transition_sequencer

Overview:
- Downstream of the DPMU policy FSM; one instance per power domain (core1, core2, mem).
- Takes the requested voltage/frequency code pair and applies it to the regulator and PLL in a safe order:
  - Raise voltage before raising frequency.
  - Lower frequency before lowering voltage.
- Handshakes with the regulator and waits for PLL lock. Flags timeouts as a sticky fault.

Parameters:
- RESET_V, 2'b01, voltage code driven after reset (matches DPMU NORMAL level).
- RESET_F, 3'b010, frequency code driven after reset.
- SETTLE_CYCLES, 8, cycles waited after vreg_ack before proceeding; range 1..255.
- LOCK_BLANK, 2, cycles after a frequency change during which pll_lock is ignored; range 1..15.
- TIMEOUT_CYCLES, 255, max cycles waiting for vreg_ack or pll_lock; range 1..255.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-low reset.
- tgt_v, input, 2, requested voltage code (level, from DPMU).
- tgt_f, input, 3, requested frequency code (level, from DPMU).
- vreg_ack, input, 1, regulator reports output reached v_out (level).
- pll_lock, input, 1, PLL locked (level).
- fault_clr, input, 1, single-cycle pulse; clears fault.
- v_out, output, 2, applied voltage code (registered).
- f_out, output, 3, applied frequency code (registered).
- vreg_req, output, 1, high while a voltage change awaits ack.
- pll_relock, output, 1, one-cycle pulse on the cycle f_out changes.
- busy, output, 1, high in any state other than IDLE and FAULT.
- done, output, 1, one-cycle pulse when a transition completes.
- fault, output, 1, sticky timeout flag.

Behaviour:
- Interface: reset reset, asynchronous, active-low; clock clk.
- Reset values: v_out=RESET_V, f_out=RESET_F; vreg_req, pll_relock, busy, done, fault all 0; state IDLE; counters 0.
- States: IDLE, V_RAISE, V_SETTLE_UP, F_SET, F_LOCK, V_LOWER, V_SETTLE_DN, FAULT.
- IDLE:
  - If {tgt_v,tgt_f} != {v_out,f_out}, latch them into tv/tf.
  - If tv>v_out, go to V_RAISE; otherwise go to F_SET.
  - If equal, stay; no outputs change.
- Target changes while busy are ignored. Latched tv/tf are used to completion, then re-evaluated in IDLE the cycle after done.
- V_RAISE / V_LOWER:
  - On entry cycle, v_out<=tv and vreg_req<=1.
  - Wait for vreg_ack==1, then vreg_req<=0 and go to the matching settle state.
  - Wait counter starts at entry; if it reaches TIMEOUT_CYCLES without ack, go to FAULT.
- V_SETTLE_UP / V_SETTLE_DN: count SETTLE_CYCLES, then:
  - UP goes to F_SET.
  - DN goes to IDLE with done=1.
- F_SET:
  - If tf==f_out, skip directly: go to V_LOWER if tv<v_out, else IDLE with done.
  - Otherwise f_out<=tf, pulse pll_relock for 1 cycle, go to F_LOCK.
- F_LOCK:
  - Ignore pll_lock for LOCK_BLANK cycles after entry.
  - Then wait for pll_lock==1. Once seen, go to V_LOWER if tv<v_out, else IDLE with done.
  - Timeout counts from F_LOCK entry (blank cycles included); on expiry go to FAULT.
- Equal voltage, different frequency: F_SET, F_LOCK, then IDLE only.
- Voltage-only change: frequency is skipped per the F_SET rule.
- Minimum latency, raise path: entry, V_RAISE (≥1 cycle), settle, F_SET, F_LOCK (≥LOCK_BLANK+1), done.
- FAULT:
  - fault=1, vreg_req=0, busy=0; v_out/f_out hold their last values.
  - Leave only on fault_clr (go to IDLE, fault<=0) or reset.
  - fault_clr in any other state has no effect.
- Simultaneous ack and timeout expiry in the same cycle: ack wins.
- Reset asserted mid-transition: immediate return to reset values. The regulator/PLL must tolerate the code jump.
- done and pll_relock never assert together with fault.

Test Plan:
- Reset release with tgt=RESET values: v_out=01, f_out=010, busy=0, no done for 50 cycles.
- Raise to tgt_v=11, tgt_f=111; vreg_ack 3 cycles after vreg_req; pll_lock high 4 cycles after pll_relock. Required order:
  - v_out=11 first.
  - After ack plus 8 settle cycles, f_out=111 with pll_relock pulse.
  - done exactly 1 cycle after lock observed.
  - f_out never changes while v_out=01.
- Lower from 11/111 to 00/000: f_out=000 and lock first; then v_out=00, vreg_req, ack, 8 settle cycles, done. v_out stays 11 until lock is seen.
- Frequency-only change 01/010 to 01/001: no vreg_req; pll_relock pulse; pll_lock held high throughout is ignored for 2 cycles, then done.
- Hold vreg_ack=0 during a raise: fault=1 after 255 cycles, vreg_req=0, outputs frozen, tgt changes ignored. fault_clr clears fault, and the sequence restarts next cycle.
- Change tgt mid-raise (11/111 to 00/000): the first transition completes with done, then the lowering sequence starts automatically. Assert reset mid-F_LOCK: v_out/f_out return to 01/010 immediately.
